// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-conversion datapath.
//   GRAY_W       width of every Gray/binary word handled here
//   out_state_e  occupancy of the single-entry output stage
//   gray2bin     4-bit Gray-to-binary XOR chain. gray_to_binary calls this
//                function, so the module and any other user share one set of
//                equations.
// -----------------------------------------------------------------------------
package gray_pkg;

  localparam int GRAY_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // B3 = G3, then each lower bit folds in the next Gray bit.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/gray_conv_arbiter_if.sv
// -----------------------------------------------------------------------------
// gray_conv_arbiter_if
// Bundles the requester-side and consumer-side handshake of gray_conv_arbiter.
//   req_valid / req_gray / req_ready : N_REQ requesters, 4-bit Gray word each
//                                      (requester i at bits [4i+3:4i])
//   out_valid / out_bin / out_id / out_ready : single binary result channel
//   conv_cnt                         : running count of accepted conversions
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus consumer)
// -----------------------------------------------------------------------------
interface gray_conv_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
);
  import gray_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [GRAY_W*N_REQ-1:0] req_gray;
  logic [N_REQ-1:0]        req_ready;
  logic                    out_valid;
  logic [GRAY_W-1:0]       out_bin;
  logic [ID_W-1:0]         out_id;
  logic                    out_ready;
  logic [CNT_W-1:0]        conv_cnt;

  modport slave (
    input  req_valid, req_gray, out_ready,
    output req_ready, out_valid, out_bin, out_id, conv_cnt
  );

  modport master (
    output req_valid, req_gray, out_ready,
    input  req_ready, out_valid, out_bin, out_id, conv_cnt
  );

endinterface

// File: rtl/gray_to_binary.sv
// -----------------------------------------------------------------------------
// gray_to_binary
// Combinational 4-bit Gray-to-binary converter.
//   gray : Gray-coded input
//   bin  : binary equivalent
// -----------------------------------------------------------------------------
module gray_to_binary
  import gray_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  output logic [GRAY_W-1:0] bin
);

  assign bin = gray2bin(gray);

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. It can be reused by any block
// that shares one datapath among several requesters.
//   req       : request vector
//   ptr       : highest-priority index (must be < N_REQ)
//   en        : when low, no grant bit is raised (grant_idx/grant_any are
//               still reported)
//   grant     : one-hot grant, or zero
//   grant_idx : index of the first request at or after ptr, with wrap
//   grant_any : at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  // Walk the requests starting at ptr. The first hit wins. Because ptr is
  // below N_REQ, one subtraction is enough to wrap the index.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant_idx  = IDX_W'(idx);
        grant[idx] = en;
      end
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// gray_conv_arbiter
// Shares one Gray-to-binary converter among N_REQ requesters. Requesters are
// served in round-robin order. The result is held in a single-entry output
// register and tagged with the index of the requester that produced it.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : gray_conv_arbiter_if.slave, which carries these signals:
//          req_valid, req_gray, req_ready  (requester side)
//          out_valid, out_bin, out_id, out_ready  (consumer side)
//          conv_cnt  (accepted-conversion counter, wraps)
// -----------------------------------------------------------------------------
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  gray_conv_arbiter_if.slave    bus
);

  out_state_e        state_q, state_d;
  logic [GRAY_W-1:0] out_bin_q, out_bin_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  conv_cnt_q, conv_cnt_d;

  logic              can_accept;
  logic              arb_en;
  logic              granted;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic [GRAY_W-1:0] sel_gray;
  logic [GRAY_W-1:0] sel_bin;

  // A full stage can still take a new word when the consumer drains it in
  // the same cycle. Reset masks every grant.
  assign can_accept = (state_q == EMPTY) || bus.out_ready;
  assign arb_en     = can_accept && !rst;
  assign granted    = grant_any && arb_en;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // AND-OR mux driven by the one-hot grant. This avoids a variable part-select
  // whose offset arithmetic would overflow ID_W.
  always_comb begin
    sel_gray = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_gray = sel_gray | (bus.req_gray[i*GRAY_W +: GRAY_W] & {GRAY_W{grant[i]}});
    end
  end

  gray_to_binary u_conv (
    .gray (sel_gray),
    .bin  (sel_bin)
  );

  // Next-state logic for the output stage, the priority pointer and the
  // counter. A grant loads a new result, which also covers the case where the
  // old result drains in the same cycle. A drain with no grant only clears
  // the occupancy, so out_bin and out_id keep their last values.
  always_comb begin
    state_d    = state_q;
    out_bin_d  = out_bin_q;
    out_id_d   = out_id_q;
    ptr_d      = ptr_q;
    conv_cnt_d = conv_cnt_q;
    if (granted) begin
      state_d    = FULL;
      out_bin_d  = sel_bin;
      out_id_d   = grant_idx;
      ptr_d      = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      conv_cnt_d = conv_cnt_q + 1'b1;
    end else if (state_q == FULL && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_bin_q  <= '0;
      out_id_q   <= '0;
      ptr_q      <= '0;
      conv_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      out_bin_q  <= out_bin_d;
      out_id_q   <= out_id_d;
      ptr_q      <= ptr_d;
      conv_cnt_q <= conv_cnt_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_bin   = out_bin_q;
  assign bus.out_id    = out_id_q;
  assign bus.conv_cnt  = conv_cnt_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gray_conv_arbiter
// Directed bench for gray_conv_arbiter. It uses a 4-requester instance with a
// 16-bit counter, plus a second instance with a 2-bit counter that sees the
// same stimulus so that counter wrap can be observed.
// -----------------------------------------------------------------------------
module tb_gray_conv_arbiter;
  import gray_pkg::*;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  gray_conv_arbiter_if #(.N_REQ(4), .ID_W(2), .CNT_W(16)) bus ();
  gray_conv_arbiter_if #(.N_REQ(4), .ID_W(2), .CNT_W(2))  bus_small ();

  assign bus_small.req_valid = bus.req_valid;
  assign bus_small.req_gray  = bus.req_gray;
  assign bus_small.out_ready = bus.out_ready;

  gray_conv_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  gray_conv_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(2)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus_small.slave)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drives a new input vector at the falling edge, then waits 1 unit so that
  // the combinational req_ready has settled before it is checked.
  task automatic applyStimulus(input logic rst_v, input logic [3:0] valid,
                               input logic [15:0] gray, input logic ready);
    @(negedge clk);
    rst           = rst_v;
    bus.req_valid = valid;
    bus.req_gray  = gray;
    bus.out_ready = ready;
    #1;
  endtask

  // Moves to 1 unit after the next rising edge, where registered outputs
  // are stable.
  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_bin [5];
  logic [1:0] exp_gnt [5];

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_gray  = '0;
    bus.out_ready = 1'b0;

    // Reset state. req_ready must stay low even with every requester valid.
    applyStimulus(1'b1, 4'b1111, 16'h0000, 1'b1);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
    waitEdge();
    applyStimulus(1'b1, 4'b1111, 16'h0000, 1'b1);
    waitEdge();
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_out_bin",   32'(bus.out_bin),   32'h0);
    checkOutput("rst_out_id",    32'(bus.out_id),    32'h0);
    checkOutput("rst_conv_cnt",  32'(bus.conv_cnt),  32'h0);

    // Test 1: a single requester. Gray 1101 converts to binary 1001.
    applyStimulus(1'b0, 4'b0001, 16'h000D, 1'b1);
    checkOutput("t1_req_ready", 32'(bus.req_ready), 32'h1);
    waitEdge();
    checkOutput("t1_out_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("t1_out_bin",   32'(bus.out_bin),   32'h9);
    checkOutput("t1_out_id",    32'(bus.out_id),    32'h0);
    checkOutput("t1_conv_cnt",  32'(bus.conv_cnt),  32'h1);

    // Reset again so that test 2 starts with ptr=0 and both counters at 0.
    applyStimulus(1'b1, 4'b0000, 16'h0000, 1'b1);
    waitEdge();

    // Test 2: all four requesters valid. Grants rotate 0,1,2,3,0.
    // Gray r0=0001 -> 0001, r1=0110 -> 0100, r2=1000 -> 1111, r3=0000 -> 0000.
    exp_gnt[0] = 2'd0; exp_bin[0] = 4'b0001;
    exp_gnt[1] = 2'd1; exp_bin[1] = 4'b0100;
    exp_gnt[2] = 2'd2; exp_bin[2] = 4'b1111;
    exp_gnt[3] = 2'd3; exp_bin[3] = 4'b0000;
    exp_gnt[4] = 2'd0; exp_bin[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'b1111, 16'h0861, 1'b1);
      checkOutput($sformatf("t2_req_ready_%0d", k), 32'(bus.req_ready),
                  32'(4'b0001 << exp_gnt[k]));
      waitEdge();
      checkOutput($sformatf("t2_out_bin_%0d", k), 32'(bus.out_bin), 32'(exp_bin[k]));
      checkOutput($sformatf("t2_out_id_%0d", k),  32'(bus.out_id),  32'(exp_gnt[k]));
      checkOutput($sformatf("t2_out_valid_%0d", k), 32'(bus.out_valid), 32'h1);
    end
    checkOutput("t2_conv_cnt",       32'(bus.conv_cnt),       32'd5);
    checkOutput("t2_conv_cnt_wrap2", 32'(bus_small.conv_cnt), 32'd1);

    // Test 3: backpressure. The held result is bin 0001 from r0, and r2
    // is requesting.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4'b0100, 16'h0861, 1'b0);
      checkOutput($sformatf("t3_stall_ready_%0d", k), 32'(bus.req_ready), 32'h0);
      waitEdge();
      checkOutput($sformatf("t3_stall_valid_%0d", k), 32'(bus.out_valid), 32'h1);
      checkOutput($sformatf("t3_stall_bin_%0d", k),   32'(bus.out_bin),   32'h1);
      checkOutput($sformatf("t3_stall_id_%0d", k),    32'(bus.out_id),    32'h0);
    end
    applyStimulus(1'b0, 4'b0100, 16'h0861, 1'b1);
    checkOutput("t3_release_ready", 32'(bus.req_ready), 32'h4);
    waitEdge();
    checkOutput("t3_release_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("t3_release_bin",   32'(bus.out_bin),   32'hF);
    checkOutput("t3_release_id",    32'(bus.out_id),    32'h2);
    checkOutput("t3_conv_cnt",      32'(bus.conv_cnt),  32'd6);

    // Test 4: drain with no requests. out_bin and out_id keep their values.
    applyStimulus(1'b0, 4'b0000, 16'h0861, 1'b1);
    checkOutput("t4_req_ready", 32'(bus.req_ready), 32'h0);
    waitEdge();
    checkOutput("t4_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("t4_out_bin",   32'(bus.out_bin),   32'hF);
    checkOutput("t4_out_id",    32'(bus.out_id),    32'h2);

    // Test 5: grant r0 so that ptr moves to 1. Then with r0 and r3 valid,
    // r3 must win.
    applyStimulus(1'b0, 4'b0001, 16'h0861, 1'b1);
    checkOutput("t5_setup_ready", 32'(bus.req_ready), 32'h1);
    waitEdge();
    applyStimulus(1'b0, 4'b1001, 16'h0861, 1'b1);
    checkOutput("t5_r3_ready", 32'(bus.req_ready), 32'h8);
    waitEdge();
    checkOutput("t5_r3_id",  32'(bus.out_id),  32'h3);
    checkOutput("t5_r3_bin", 32'(bus.out_bin), 32'h0);
    // r0 requests while the stage is stalled, then withdraws.
    applyStimulus(1'b0, 4'b0001, 16'h0861, 1'b0);
    checkOutput("t5_stall_ready", 32'(bus.req_ready), 32'h0);
    waitEdge();
    applyStimulus(1'b0, 4'b0000, 16'h0861, 1'b1);
    checkOutput("t5_withdraw_ready", 32'(bus.req_ready), 32'h0);
    waitEdge();
    checkOutput("t5_withdraw_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("t5_withdraw_cnt",   32'(bus.conv_cnt),  32'd8);
    // ptr must still be 0, so with all four valid r0 is granted first.
    applyStimulus(1'b0, 4'b1111, 16'h0861, 1'b1);
    checkOutput("t5_ptr_probe", 32'(bus.req_ready), 32'h1);
    waitEdge();
    checkOutput("t5_probe_valid", 32'(bus.out_valid), 32'h1);

    // Test 6: reset while a result is pending.
    applyStimulus(1'b1, 4'b1111, 16'h0861, 1'b1);
    checkOutput("t6_rst_ready", 32'(bus.req_ready), 32'h0);
    waitEdge();
    checkOutput("t6_out_valid",  32'(bus.out_valid),      32'h0);
    checkOutput("t6_conv_cnt",   32'(bus.conv_cnt),       32'h0);
    checkOutput("t6_cnt_small",  32'(bus_small.conv_cnt), 32'h0);
    checkOutput("t6_out_id",     32'(bus.out_id),         32'h0);
    applyStimulus(1'b0, 4'b0000, 16'h0000, 1'b0);
    waitEdge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
